// File: rtl/bus_gpio_pkg.sv
// Shared constants and types for the bus_gpio slave.
// Word indices are decoded from bAddr[4:2]; byte offset = index * 4.
package bus_gpio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned WIDX_W = 3;

    typedef logic [WIDX_W-1:0] gpio_widx_t;

    localparam gpio_widx_t GPIO_OFF_DOUT  = 3'd0;  // 0x00
    localparam gpio_widx_t GPIO_OFF_DIR   = 3'd1;  // 0x04
    localparam gpio_widx_t GPIO_OFF_DIN   = 3'd2;  // 0x08
    localparam gpio_widx_t GPIO_OFF_IEN   = 3'd3;  // 0x0C
    localparam gpio_widx_t GPIO_OFF_ISTAT = 3'd4;  // 0x10
    localparam gpio_widx_t GPIO_OFF_IPOL  = 3'd5;  // 0x14
    localparam gpio_widx_t GPIO_OFF_SET   = 3'd6;  // 0x18
    localparam gpio_widx_t GPIO_OFF_CLR   = 3'd7;  // 0x1C

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad-input synchronizer chain plus one history flop for edge detection.
// rise_c/fall_c are combinational from flops and valid for exactly one cycle per edge.
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] rise_c,
    output logic [WIDTH-1:0] fall_c
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev_in;

    // chain[0] takes the raw pin; the last stage is the synchronized value
    always_ff @(posedge clk) begin
        if (rst) begin
            chain   <= '0;
            prev_in <= '0;
        end else begin
            chain   <= {chain[SYNC_STAGES-2:0], pin};
            prev_in <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_in = chain[SYNC_STAGES-1];
    assign rise_c  = sync_in & ~prev_in;
    assign fall_c  = ~sync_in & prev_in;

endmodule

// File: rtl/bus_gpio.sv
// GPIO slave (bus slot 1): register file, read mux, edge interrupts.
// Optional GPIO_SETCLR_EN enables write-only DATA_SET (0x18) / DATA_CLR (0x1C).
module bus_gpio
    import bus_gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bSel,
    input  logic [31:0]      bAddr,
    input  logic             bWe,
    input  logic [31:0]      bWData,
    output logic [31:0]      bRData,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] ien;
    logic [WIDTH-1:0] istat;
    logic [WIDTH-1:0] ipol;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] ev_c;
    logic [WIDTH-1:0] clr_c;
    logic [WIDTH-1:0] wdata_c;
    logic [BUS_W-1:0] rdata_c;
    logic             wr_c;
    logic             rd_c;
    gpio_widx_t       widx_c;

    // Address bits outside [4:2] and write-data bits above WIDTH are don't-care
    logic unused_bits;
    assign unused_bits = ^{bAddr[31:5], bAddr[1:0], bWData};

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .pin     (gpio_in),
        .sync_in (sync_in),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    assign widx_c  = bAddr[4:2];
    assign wr_c    = bSel & bWe;
    assign rd_c    = bSel & ~bWe;
    assign wdata_c = bWData[WIDTH-1:0];
    assign ev_c    = (ipol & rise_c) | (~ipol & fall_c);
    assign clr_c   = (wr_c && (widx_c == GPIO_OFF_ISTAT)) ? wdata_c : '0;

    // Read mux; reserved / write-only slots return 0
    always_comb begin
        rdata_c = '0;
        unique case (widx_c)
            GPIO_OFF_DOUT:  rdata_c = BUS_W'(dout);
            GPIO_OFF_DIR:   rdata_c = BUS_W'(dir);
            GPIO_OFF_DIN:   rdata_c = BUS_W'(sync_in);
            GPIO_OFF_IEN:   rdata_c = BUS_W'(ien);
            GPIO_OFF_ISTAT: rdata_c = BUS_W'(istat);
            GPIO_OFF_IPOL:  rdata_c = BUS_W'(ipol);
            default:        rdata_c = '0;
        endcase
    end

    // Register file; in IRQ_STAT a new event overrides a same-cycle W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= '0;
            dir    <= '0;
            ien    <= '0;
            istat  <= '0;
            ipol   <= '0;
            irq    <= 1'b0;
            bRData <= '0;
        end else begin
            if (wr_c) begin
                unique case (widx_c)
                    GPIO_OFF_DOUT: dout <= wdata_c;
                    GPIO_OFF_DIR:  dir  <= wdata_c;
                    GPIO_OFF_IEN:  ien  <= wdata_c;
                    GPIO_OFF_IPOL: ipol <= wdata_c;
`ifdef GPIO_SETCLR_EN
                    GPIO_OFF_SET:  dout <= dout | wdata_c;
                    GPIO_OFF_CLR:  dout <= dout & ~wdata_c;
`endif
                    default: ;
                endcase
            end
            istat <= (istat & ~clr_c) | ev_c;
            irq   <= |(istat & ien);
            if (rd_c) begin
                bRData <= rdata_c;
            end
        end
    end

    assign gpio_out = dout;
    assign gpio_oe  = dir;

endmodule

// File: tb/tb_bus_gpio.sv
// Scoreboard bench for bus_gpio: stimulus queues expectations tagged with the
// cycle they become due; a negedge monitor pops and compares them.
module tb_bus_gpio;

    localparam int unsigned WIDTH = 8;

    localparam int SEL_RDATA = 0;
    localparam int SEL_OUT   = 1;
    localparam int SEL_OE    = 2;
    localparam int SEL_IRQ   = 3;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bSel = 1'b0;
    logic [31:0]      bAddr = '0;
    logic             bWe = 1'b0;
    logic [31:0]      bWData = '0;
    logic [31:0]      bRData;
    logic [WIDTH-1:0] gpio_in = '0;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    bus_gpio #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bSel     (bSel),
        .bAddr    (bAddr),
        .bWe      (bWe),
        .bWData   (bWData),
        .bRData   (bRData),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SEL_RDATA: return bRData;
            SEL_OUT:   return 32'(gpio_out);
            SEL_OE:    return 32'(gpio_oe);
            default:   return 32'(irq);
        endcase
    endfunction

    // Monitor: compare every expectation that has come due
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = pick(e.sel);
            checks++;
            if (e.cyc != cyc || act !== e.exp)
                $display("FAIL %s: got 0x%08h expected 0x%08h (due cyc %0d, now %0d)",
                         e.name, act, e.exp, e.cyc, cyc);
            else
                passed++;
        end
    end

    task automatic push(input int due, input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc = due; e.sel = sel; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Due at the next negedge (state after the most recent edge)
    task automatic expect_now(input int sel, input logic [31:0] exp, input string name);
        push(cyc, sel, exp, name);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bSel = 1'b1; bWe = 1'b1; bAddr = addr; bWData = data;
        tick();
        bSel = 1'b0; bWe = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        push(cyc + 1, SEL_RDATA, exp, name);
        bSel = 1'b1; bWe = 1'b0; bAddr = addr;
        tick();
        bSel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles
        idle(2);
        rst = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0)
            $display("FAIL direct_rst_irq: got %b expected 0", irq);
        else
            passed++;
        expect_now(SEL_RDATA, 32'h0, "rst_rdata");
        expect_now(SEL_OUT,   32'h0, "rst_out");
        expect_now(SEL_OE,    32'h0, "rst_oe");
        expect_now(SEL_IRQ,   32'h0, "rst_irq");
        for (int a = 0; a < 8; a++) bus_read(32'(a * 4), 32'h0, "rst_read");

        // Basic writes and readback
        push(cyc + 1, SEL_OUT, 32'hA5, "wr_dout_pin");
        bus_write(32'h00, 32'h0000_00A5);
        checks++;
        if (gpio_out !== 8'hA5)
            $display("FAIL direct_dout: got 0x%02h expected 0xa5", gpio_out);
        else
            passed++;
        push(cyc + 1, SEL_OE, 32'hF0, "wr_dir_pin");
        bus_write(32'h04, 32'h0000_00F0);
        checks++;
        if (gpio_oe !== 8'hF0)
            $display("FAIL direct_dir: got 0x%02h expected 0xf0", gpio_oe);
        else
            passed++;
        expect_now(SEL_RDATA, 32'h0, "rdata_hold_on_write");
        bus_read(32'h00, 32'hA5, "rd_dout");
        bus_read(32'h04, 32'hF0, "rd_dir");
        bus_write(32'h08, 32'h0000_00FF);
        expect_now(SEL_RDATA, 32'hF0, "rdata_hold_after_write");
        bus_read(32'h0B, 32'h00, "rd_din_ignores_write");

        // Input synchronizer latency: visible after two edges
        gpio_in = 8'h3C;
        bus_read(32'h08, 32'h00, "din_lat1");
        bus_read(32'h08, 32'h00, "din_lat2");
        bus_read(32'h08, 32'h3C, "din_lat3");
        bus_read(32'h18, 32'h00, "rd_0x18");
        bus_read(32'h1C, 32'h00, "rd_0x1C");

        // Edge interrupts: bit0 rising, bit1 falling
        bus_write(32'h14, 32'h01);
        bus_write(32'h0C, 32'h03);
        gpio_in = 8'h3E;
        idle(5);
        bus_read(32'h10, 32'h00, "stat_pin1_rise_no_event");
        gpio_in = 8'h3F;
        idle(5);
        expect_now(SEL_IRQ, 32'h1, "irq_after_bit0");
        gpio_in = 8'h3D;
        idle(5);
        bus_read(32'h10, 32'h03, "stat_both");
        expect_now(SEL_IRQ, 32'h1, "irq_both");
        bus_write(32'h10, 32'h01);
        bus_read(32'h10, 32'h02, "stat_after_w1c0");
        expect_now(SEL_IRQ, 32'h1, "irq_still_set");
        push(cyc + 1, SEL_IRQ, 32'h1, "irq_lags_clear");
        bus_write(32'h10, 32'h02);
        push(cyc + 1, SEL_IRQ, 32'h0, "irq_cleared");
        tick();
        bus_read(32'h10, 32'h00, "stat_clear");

        // Set wins over a same-cycle W1C
        gpio_in = 8'h3C;
        idle(5);
        gpio_in = 8'h3D;
        idle(2);
        bus_write(32'h10, 32'h01);
        bus_read(32'h10, 32'h01, "set_wins");
        bus_write(32'h10, 32'h01);
        bus_read(32'h10, 32'h00, "w1c_after_set_wins");

        // Polarity change alone raises no event
        bus_write(32'h14, 32'h00);
        idle(3);
        bus_read(32'h10, 32'h00, "ipol_change_no_event");

        // DIR change leaves DATA_OUT alone; upper bits masked
        push(cyc + 1, SEL_OE, 32'h0F, "dir_new");
        bus_write(32'h04, 32'h0F);
        bus_read(32'h00, 32'hA5, "dout_after_dir");
        push(cyc + 1, SEL_OUT, 32'h5A, "dout_masked_pin");
        bus_write(32'h00, 32'hFFFF_FF5A);
        bus_read(32'h00, 32'h5A, "dout_masked_rd");

`ifdef GPIO_SETCLR_EN
        bus_write(32'h00, 32'h0F);
        bus_write(32'h18, 32'h30);
        bus_read(32'h00, 32'h3F, "data_set");
        bus_write(32'h1C, 32'h05);
        bus_read(32'h00, 32'h3A, "data_clr");
        bus_read(32'h18, 32'h00, "set_reads_0");
`else
        bus_write(32'h18, 32'h30);
        bus_write(32'h1C, 32'hFF);
        bus_read(32'h00, 32'h5A, "reserved_write_ignored");
        bus_read(32'h1C, 32'h00, "reserved_reads_0");
`endif

        // Reset mid-operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (gpio_out !== 8'h00)
            $display("FAIL direct_mid_rst_out: got 0x%02h expected 0x00", gpio_out);
        else
            passed++;
        checks++;
        if (gpio_oe !== 8'h00)
            $display("FAIL direct_mid_rst_oe: got 0x%02h expected 0x00", gpio_oe);
        else
            passed++;
        expect_now(SEL_RDATA, 32'h0, "mid_rst_rdata");
        expect_now(SEL_OUT,   32'h0, "mid_rst_out");
        expect_now(SEL_OE,    32'h0, "mid_rst_oe");
        expect_now(SEL_IRQ,   32'h0, "mid_rst_irq");
        idle(3);
        bus_read(32'h08, 32'h3D, "din_after_rst");
        bus_read(32'h10, 32'h00, "stat_after_rst");

        idle(3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            $display("FAIL %s: got unchecked expected checked (due cyc %0d)", e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bus_gpio.md
Name: bus_gpio

Overview:
GPIO slave on the shared 32-bit system bus; occupies slave slot 1. Its read data feeds the bus read mux on the GPIO input.
- Receives the decoder's select line, address, write data and write strobe.
- Returns registered read data.
- Drives pad outputs and output enables.
- Synchronizes pad inputs and raises a level interrupt on configurable edges.

Parameters:
WIDTH, 8, number of GPIO pins (1..32); register bits above WIDTH read 0 and ignore writes.
SYNC_STAGES, 2, flip-flop stages on each gpio_in bit (minimum 2).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
bSel  input  1  slave select from bus decoder (this slave's bit).
bAddr  input  32  byte address; only bAddr[4:2] decoded, bAddr[1:0] ignored.
bWe  input  1  write strobe, qualified by bSel.
bWData  input  32  write data.
bRData  output  32  registered read data to the bus mux.
gpio_in  input  WIDTH  asynchronous pad inputs.
gpio_out  output  WIDTH  pad output values (= DATA_OUT register).
gpio_oe  output  WIDTH  pad output enables (= DIR register, 1 = drive).
irq  output  1  level interrupt, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous, active-high.
- Reset state: bRData=0, gpio_out=0, gpio_oe=0, irq=0. All registers and synchronizer/edge flops are 0.
- Register map (offset = bAddr[4:2]*4):
  - 0x00 DATA_OUT: RW.
  - 0x04 DIR: RW.
  - 0x08 DATA_IN: RO; synchronized pins.
  - 0x0C IRQ_EN: RW.
  - 0x10 IRQ_STAT: RW1C.
  - 0x14 IRQ_POL: RW; 1 = rising edge, 0 = falling edge.
  - 0x18 and 0x1C: reserved; read 0, writes ignored (see optional feature).
- Write: occurs when bSel & bWe. Target register updates at that clk edge; the new value is visible on gpio_out/gpio_oe on the next cycle. Writes to DATA_IN have no effect.
- Read: when bSel & ~bWe, bRData loads the addressed register on that edge (1-cycle latency). Otherwise bRData holds its last value. The master samples bRData the cycle after the access.
- Read on a write cycle: bRData holds its previous value.
- Input path:
  - gpio_in passes through SYNC_STAGES flops to give sync_in (DATA_IN).
  - One more flop gives prev_in.
  - rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
  - Pin-to-DATA_IN latency is SYNC_STAGES cycles.
- Event: ev[i] = IRQ_POL[i] ? rise[i] : fall[i].
  - IRQ_STAT[i] sets on ev[i], regardless of IRQ_EN.
  - Write-1 at 0x10 clears the bit.
  - Same-cycle set and clear on one bit: set wins; the bit stays 1.
- Interrupt: irq is registered as |(IRQ_STAT & IRQ_EN), so it lags IRQ_STAT by one cycle.
- Configuration changes:
  - Changing IRQ_POL does not itself generate an event.
  - Changing DIR does not alter DATA_OUT.
- Reset mid-operation: all state is cleared in the same cycle. The first pin value after reset produces no spurious edge, because prev_in is also 0 and pins at 0 give no edge. A pin held high through reset produces a rising event once synchronized; this is intended behaviour.

Optional Feature:
GPIO_SETCLR_EN
- Defined: 0x18 DATA_SET and 0x1C DATA_CLR are write-only.
  - DATA_OUT |= wdata (SET) or DATA_OUT &= ~wdata (CLR), for atomic pin control.
  - Both read 0.
- Not defined: 0x18 and 0x1C are reserved, as listed in the register map.

Decomposition:
- Package bus_gpio_pkg holds:
  - Offset constants: GPIO_OFF_DOUT, GPIO_OFF_DIR, GPIO_OFF_DIN, GPIO_OFF_IEN, GPIO_OFF_ISTAT, GPIO_OFF_IPOL, GPIO_OFF_SET, GPIO_OFF_CLR.
  - Word-index typedef for bAddr[4:2].
- Sub-module gpio_sync_edge (params WIDTH, SYNC_STAGES) contains the synchronizer chain, prev flop and rise/fall outputs.
- Register file and read mux stay in bus_gpio.

Test Plan:
- Reset: assert rst 2 cycles, release -> bRData=0, gpio_out=0, gpio_oe=0, irq=0; reads of every offset return 0.
- Writes: write 0xA5 to 0x00 and 0xF0 to 0x04 -> next cycle gpio_out=0xA5, gpio_oe=0xF0. Readback of each returns that value, 1 cycle after the read select. Write to 0x08 has no effect.
- Input sync: drive gpio_in=0x3C -> DATA_IN reads 0x3C no earlier than 2 cycles later (SYNC_STAGES=2). Reads of 0x18/0x1C return 0 without the macro.
- Edge interrupt:
  - IRQ_POL=0x01, IRQ_EN=0x03.
  - Pulse gpio_in[0] 0→1, then pin1 1→0 -> IRQ_STAT=0x03, irq=1.
  - Write 0x01 to 0x10 -> STAT=0x02, irq stays 1.
  - Write 0x02 -> irq=0 one cycle after STAT clears.
- Set-wins: issue a W1C of bit0 in the same cycle a rising event on bit0 is detected -> IRQ_STAT[0]=1.
- GPIO_SETCLR_EN: DATA_OUT=0x0F, write 0x30 to 0x18 -> 0x3F. Write 0x05 to 0x1C -> 0x3A. Read of 0x18 returns 0.
